// File: rtl/ex_stage_seq.sv
// rtl/ex_stage_seq.sv - pipeline execute stage with single-cycle ALU and 64-cycle shift-add multiplier
module ex_stage_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] PC,
    input  logic [63:0] ReadData1,
    input  logic [63:0] ReadData2,
    input  logic [63:0] imm_data,
    input  logic [4:0]  rd,
    input  logic [3:0]  Funct,
    input  logic [1:0]  ALUOp,
    input  logic        ALUSrc,
    input  logic        Branch,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        Regwrite,
    input  logic        MemtoReg,
    output logic        valid_out,
    output logic [63:0] ALU_result,
    output logic [63:0] WriteData,
    output logic [63:0] branch_target,
    output logic        Zero,
    output logic        PCSrc,
    output logic [4:0]  rd_out,
    output logic        Branch_out,
    output logic        MemRead_out,
    output logic        MemWrite_out,
    output logic        Regwrite_out,
    output logic        MemtoReg_out
);

    typedef enum logic {IDLE, MUL} state_t;

    state_t      state;
    state_t      state_next;
    logic [5:0]  count;

    // Multiplier working registers and the instruction fields held while it runs
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] mul_acc;
    logic [63:0] hold_pc;
    logic [63:0] hold_imm;
    logic [63:0] hold_wd;
    logic [4:0]  hold_rd;
    logic [4:0]  hold_ctl;

    logic [63:0] op_b;
    logic [63:0] alu_out;
    logic [63:0] acc_next;
    logic        accept;
    logic        is_mul;
    logic        mul_done;
    logic        load;

    // Completion operands: live ID/EX fields for single-cycle ops, held fields for a multiply
    logic [63:0] sel_result;
    logic [63:0] sel_pc;
    logic [63:0] sel_imm;
    logic [63:0] sel_wd;
    logic [4:0]  sel_rd;
    logic [4:0]  sel_ctl;
    logic        sel_zero;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid & in_ready;
    assign is_mul   = (ALUOp == 2'b11);
    assign op_b     = ALUSrc ? imm_data : ReadData2;
    assign acc_next = mul_acc + (mul_b[0] ? mul_a : 64'd0);
    assign mul_done = (state == MUL) && (count == 6'd63);
    assign load     = (accept && !is_mul) || mul_done;

    assign sel_result = (state == MUL) ? acc_next : alu_out;
    assign sel_pc     = (state == MUL) ? hold_pc  : PC;
    assign sel_imm    = (state == MUL) ? hold_imm : imm_data;
    assign sel_wd     = (state == MUL) ? hold_wd  : ReadData2;
    assign sel_rd     = (state == MUL) ? hold_rd  : rd;
    assign sel_ctl    = (state == MUL) ? hold_ctl : {Branch, MemRead, MemWrite, Regwrite, MemtoReg};
    assign sel_zero   = (sel_result == 64'd0);

    // Single-cycle ALU; multiply codes produce 0 here and are handled by the iterative path
    always_comb begin
        alu_out = 64'd0;
        case (ALUOp)
            2'b00: alu_out = ReadData1 + op_b;
            2'b01: alu_out = ReadData1 - op_b;
            2'b10: begin
                case (Funct)
                    4'b0000: alu_out = ReadData1 + op_b;
                    4'b1000: alu_out = ReadData1 - op_b;
                    4'b0111: alu_out = ReadData1 & op_b;
                    4'b0110: alu_out = ReadData1 | op_b;
                    4'b0100: alu_out = ReadData1 ^ op_b;
                    4'b0001: alu_out = ReadData1 << op_b[5:0];
                    4'b0101: alu_out = ReadData1 >> op_b[5:0];
                    4'b1101: alu_out = $signed(ReadData1) >>> op_b[5:0];
                    4'b0010: alu_out = {63'd0, ($signed(ReadData1) < $signed(op_b))};
                    4'b0011: alu_out = {63'd0, (ReadData1 < op_b)};
                    default: alu_out = 64'd0;
                endcase
            end
            default: alu_out = 64'd0;
        endcase
    end

    // Next-state: a multiply accept enters MUL, the 64th iteration returns to IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && is_mul) state_next = MUL;
            MUL:     if (count == 6'd63) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Multiplier iteration: latch operands on accept, one shift-add step per MUL cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= 6'd0;
            mul_a    <= 64'd0;
            mul_b    <= 64'd0;
            mul_acc  <= 64'd0;
            hold_pc  <= 64'd0;
            hold_imm <= 64'd0;
            hold_wd  <= 64'd0;
            hold_rd  <= 5'd0;
            hold_ctl <= 5'd0;
        end else if (state == IDLE) begin
            if (accept && is_mul) begin
                count    <= 6'd0;
                mul_a    <= ReadData1;
                mul_b    <= op_b;
                mul_acc  <= 64'd0;
                hold_pc  <= PC;
                hold_imm <= imm_data;
                hold_wd  <= ReadData2;
                hold_rd  <= rd;
                hold_ctl <= {Branch, MemRead, MemWrite, Regwrite, MemtoReg};
            end
        end else begin
            count   <= count + 6'd1;
            mul_a   <= mul_a << 1;
            mul_b   <= mul_b >> 1;
            mul_acc <= acc_next;
        end
    end

    // EX/MEM register: load on completion, otherwise emit a bubble and hold data fields
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_out     <= 1'b0;
            ALU_result    <= 64'd0;
            WriteData     <= 64'd0;
            branch_target <= 64'd0;
            Zero          <= 1'b0;
            PCSrc         <= 1'b0;
            rd_out        <= 5'd0;
            Branch_out    <= 1'b0;
            MemRead_out   <= 1'b0;
            MemWrite_out  <= 1'b0;
            Regwrite_out  <= 1'b0;
            MemtoReg_out  <= 1'b0;
        end else if (load) begin
            valid_out     <= 1'b1;
            ALU_result    <= sel_result;
            WriteData     <= sel_wd;
            branch_target <= sel_pc + (sel_imm << 1);
            Zero          <= sel_zero;
            PCSrc         <= sel_ctl[4] & sel_zero;
            rd_out        <= sel_rd;
            Branch_out    <= sel_ctl[4];
            MemRead_out   <= sel_ctl[3];
            MemWrite_out  <= sel_ctl[2];
            Regwrite_out  <= sel_ctl[1];
            MemtoReg_out  <= sel_ctl[0];
        end else begin
            valid_out     <= 1'b0;
            PCSrc         <= 1'b0;
            Branch_out    <= 1'b0;
            MemRead_out   <= 1'b0;
            MemWrite_out  <= 1'b0;
            Regwrite_out  <= 1'b0;
            MemtoReg_out  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_stage_seq.sv
// tb/tb_ex_stage_seq.sv - self-checking bench for ex_stage_seq with a cycle-level reference model
module tb_ex_stage_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] PC, ReadData1, ReadData2, imm_data;
    logic [4:0]  rd;
    logic [3:0]  Funct;
    logic [1:0]  ALUOp;
    logic        ALUSrc, Branch, MemRead, MemWrite, Regwrite, MemtoReg;
    logic        valid_out;
    logic [63:0] ALU_result, WriteData, branch_target;
    logic        Zero, PCSrc;
    logic [4:0]  rd_out;
    logic        Branch_out, MemRead_out, MemWrite_out, Regwrite_out, MemtoReg_out;

    int checks = 0;
    int errors = 0;
    logic checking = 1'b0;

    ex_stage_seq dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .PC(PC), .ReadData1(ReadData1), .ReadData2(ReadData2), .imm_data(imm_data),
        .rd(rd), .Funct(Funct), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .Branch(Branch),
        .MemRead(MemRead), .MemWrite(MemWrite), .Regwrite(Regwrite), .MemtoReg(MemtoReg),
        .valid_out(valid_out), .ALU_result(ALU_result), .WriteData(WriteData),
        .branch_target(branch_target), .Zero(Zero), .PCSrc(PCSrc), .rd_out(rd_out),
        .Branch_out(Branch_out), .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out),
        .Regwrite_out(Regwrite_out), .MemtoReg_out(MemtoReg_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU from the operation table
    function automatic logic [63:0] ref_alu(input logic [1:0] op, input logic [3:0] fn,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        int sh;
        sh = int'(b % 64);
        r = 64'd0;
        if (op == 2'b00) r = a + b;
        else if (op == 2'b01) r = a - b;
        else if (op == 2'b11) r = a * b;
        else begin
            case (fn)
                4'b0000: r = a + b;
                4'b1000: r = a - b;
                4'b0111: r = a & b;
                4'b0110: r = a | b;
                4'b0100: r = a ^ b;
                4'b0001: r = a << sh;
                4'b0101: r = a >> sh;
                4'b1101: r = (a >> sh) | ((a[63] && sh != 0) ? ~(64'hFFFF_FFFF_FFFF_FFFF >> sh) : 64'd0);
                4'b0010: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
                4'b0011: r = (a < b) ? 64'd1 : 64'd0;
                default: r = 64'd0;
            endcase
        end
        return r;
    endfunction

    // Model state: expected EX/MEM contents and remaining multiply cycles
    logic [63:0] m_res = '0, m_wd = '0, m_bt = '0;
    logic [4:0]  m_rd = '0, m_ctl = '0;
    logic        m_valid = 1'b0, m_zero = 1'b0, m_pcsrc = 1'b0;
    int          mul_left = 0;
    logic [63:0] p_res, p_pc, p_imm, p_wd;
    logic [4:0]  p_rd, p_ctl;

    task automatic complete(input logic [63:0] res, input logic [63:0] pc, input logic [63:0] imm,
                            input logic [63:0] wd, input logic [4:0] r, input logic [4:0] ctl);
        m_valid = 1'b1;
        m_res = res;
        m_zero = (res == 64'd0);
        m_pcsrc = ctl[4] && (res == 64'd0);
        m_bt = pc + imm * 2;
        m_wd = wd;
        m_rd = r;
        m_ctl = ctl;
    endtask

    task automatic bubble();
        m_valid = 1'b0;
        m_pcsrc = 1'b0;
        m_ctl = 5'd0;
    endtask

    always @(posedge clk or negedge reset) begin
        logic [63:0] b;
        if (!reset) begin
            m_valid = 0; m_res = 0; m_wd = 0; m_bt = 0; m_rd = 0; m_ctl = 0;
            m_zero = 0; m_pcsrc = 0; mul_left = 0;
        end else if (mul_left > 0) begin
            mul_left = mul_left - 1;
            if (mul_left == 0) complete(p_res, p_pc, p_imm, p_wd, p_rd, p_ctl);
            else bubble();
        end else if (in_valid) begin
            b = ALUSrc ? imm_data : ReadData2;
            if (ALUOp == 2'b11) begin
                p_res = ReadData1 * b;
                p_pc = PC; p_imm = imm_data; p_wd = ReadData2; p_rd = rd;
                p_ctl = {Branch, MemRead, MemWrite, Regwrite, MemtoReg};
                mul_left = 64;
                bubble();
            end else begin
                complete(ref_alu(ALUOp, Funct, ReadData1, b), PC, imm_data, ReadData2, rd,
                         {Branch, MemRead, MemWrite, Regwrite, MemtoReg});
            end
        end else begin
            bubble();
        end
    end

    // Compare DUT against the model every cycle; data fields only when they are meaningful
    always @(negedge clk) begin
        if (checking) begin
            chk("m_in_ready", in_ready, (mul_left == 0));
            chk("m_valid_out", valid_out, m_valid);
            chk("m_ctl", {Branch_out, MemRead_out, MemWrite_out, Regwrite_out, MemtoReg_out}, m_ctl);
            chk("m_pcsrc", PCSrc, m_pcsrc);
            if (m_valid || !reset) begin
                chk("m_alu_result", ALU_result, m_res);
                chk("m_zero", Zero, m_zero);
                chk("m_write_data", WriteData, m_wd);
                chk("m_branch_target", branch_target, m_bt);
                chk("m_rd_out", rd_out, m_rd);
            end
        end
    end

    task automatic drive(input logic [1:0] op, input logic [3:0] fn, input logic [63:0] a,
                         input logic [63:0] b, input logic src, input logic [63:0] imm,
                         input logic [63:0] pc, input logic [4:0] ctl, input logic [4:0] r);
        in_valid = 1'b1;
        ALUOp = op; Funct = fn; ReadData1 = a; ReadData2 = b; ALUSrc = src;
        imm_data = imm; PC = pc; rd = r;
        {Branch, MemRead, MemWrite, Regwrite, MemtoReg} = ctl;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  fn;
        logic [63:0] a;
        logic [63:0] b;
    } vec_t;
    vec_t vecs[$];

    initial begin
        reset = 1'b0;
        drive(2'b00, 4'b0000, 64'd0, 64'd0, 1'b0, 64'd0, 64'd0, 5'd0, 5'd0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 checking = 1'b1;
        @(negedge clk);
        chk("reset_valid_out", valid_out, 1'b0);
        chk("reset_alu_result", ALU_result, 64'd0);
        chk("reset_in_ready", in_ready, 1'b1);
        reset = 1'b1;

        // ADD
        drive(2'b10, 4'b0000, 64'd5, 64'd7, 1'b0, 64'd0, 64'd0, 5'b00010, 5'd3);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("add_result", ALU_result, 64'd12);
        chk("add_zero", Zero, 1'b0);
        chk("add_rd_out", rd_out, 5'd3);
        chk("add_regwrite", Regwrite_out, 1'b1);
        chk("add_valid", valid_out, 1'b1);

        // BEQ taken
        drive(2'b01, 4'b0000, 64'h10, 64'h10, 1'b0, 64'd8, 64'h100, 5'b10000, 5'd0);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("beq_zero", Zero, 1'b1);
        chk("beq_pcsrc", PCSrc, 1'b1);
        chk("beq_target", branch_target, 64'h110);

        // Load address with negative immediate
        drive(2'b00, 4'b0000, 64'h1000, 64'h55, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 5'b01000, 5'd9);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("load_result", ALU_result, 64'hFF8);
        chk("load_memread", MemRead_out, 1'b1);
        chk("load_writedata", WriteData, 64'h55);

        // SRA of the sign bit, then a bubble
        drive(2'b10, 4'b1101, 64'h8000_0000_0000_0000, 64'd63, 1'b0, 64'd0, 64'd0, 5'b00010, 5'd4);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("sra_result", ALU_result, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        chk("bubble_valid", valid_out, 1'b0);
        chk("bubble_ctl", {Branch_out, MemRead_out, MemWrite_out, Regwrite_out, MemtoReg_out}, 5'd0);

        // Multiply, with an add waiting throughout that must only be taken after completion
        drive(2'b11, 4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1'b0, 64'd2, 64'h40, 5'b00010, 5'd7);
        @(posedge clk); #1;
        drive(2'b00, 4'b0000, 64'd1, 64'd2, 1'b0, 64'd0, 64'd0, 5'b00010, 5'd8);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            chk("mul_busy_ready", in_ready, 1'b0);
            chk("mul_busy_valid", valid_out, 1'b0);
        end
        @(negedge clk);
        chk("mul_result", ALU_result, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("mul_valid", valid_out, 1'b1);
        chk("mul_rd_out", rd_out, 5'd7);
        chk("mul_target", branch_target, 64'h44);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("after_mul_add", ALU_result, 64'd3);
        chk("after_mul_rd", rd_out, 5'd8);

        // Reset in the middle of a multiply
        drive(2'b11, 4'b0000, 64'd7, 64'd9, 1'b0, 64'd0, 64'd0, 5'b00010, 5'd5);
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (30) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_valid", valid_out, 1'b0);
        chk("rst_mid_result", ALU_result, 64'd0);
        chk("rst_mid_rd", rd_out, 5'd0);
        chk("rst_mid_ready", in_ready, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        drive(2'b10, 4'b0100, 64'hF0, 64'hFF, 1'b0, 64'd0, 64'd0, 5'b00001, 5'd2);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_accept", ALU_result, 64'h0F);
        chk("post_rst_valid", valid_out, 1'b1);
        repeat (70) @(posedge clk);

        // Table of further operations checked by the model
        vecs.push_back('{2'b00, 4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1});
        vecs.push_back('{2'b01, 4'b0000, 64'd0, 64'd1});
        vecs.push_back('{2'b10, 4'b1000, 64'd100, 64'd58});
        vecs.push_back('{2'b10, 4'b0111, 64'hF0F0, 64'hFF00});
        vecs.push_back('{2'b10, 4'b0110, 64'hF0F0, 64'h0F0F});
        vecs.push_back('{2'b10, 4'b0001, 64'd1, 64'h44});
        vecs.push_back('{2'b10, 4'b0101, 64'h8000_0000_0000_0000, 64'd63});
        vecs.push_back('{2'b10, 4'b1101, 64'h7000_0000_0000_0000, 64'd4});
        vecs.push_back('{2'b10, 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1});
        vecs.push_back('{2'b10, 4'b0011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1});
        vecs.push_back('{2'b10, 4'b1111, 64'd5, 64'd6});
        vecs.push_back('{2'b10, 4'b1010, 64'd5, 64'd6});
        vecs.push_back('{2'b11, 4'b0000, 64'd0, 64'h1234_5678});
        vecs.push_back('{2'b11, 4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF});
        vecs.push_back('{2'b11, 4'b0000, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321});
        @(posedge clk); #1;
        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].fn, vecs[i].a, vecs[i].b, 1'b0,
                  {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom), 5'($urandom));
            @(posedge clk); #1 in_valid = 1'b0;
            if (vecs[i].op == 2'b11) begin
                repeat (64) @(posedge clk);
                #1;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_stage_seq.md
EX_STAGE_SEQ -- requirements
Module: ex_stage_seq

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  asynchronous, active-low; 0 clears all state and outputs.
REQ-004 in_valid  in  1  ID/EX fields below hold a real instruction (0 = bubble).
REQ-005 in_ready  out  1  stage accepts the presented instruction this cycle.
REQ-006 PC, ReadData1, ReadData2, imm_data  in  64 each  operands from ID/EX.
REQ-007 rd  in  5; Funct  in  4 ({funct7[5],funct3}); ALUOp  in  2; ALUSrc, Branch, MemRead, MemWrite, Regwrite, MemtoReg  in  1 each.
REQ-008 valid_out  out  1  EX/MEM fields below hold a completed instruction.
REQ-009 ALU_result, WriteData, branch_target  out  64 each; Zero, PCSrc  out  1 each.
REQ-010 rd_out  out  5; Branch_out, MemRead_out, MemWrite_out, Regwrite_out, MemtoReg_out  out  1 each.

Function
REQ-011 SHALL implement FSM states IDLE and MUL; reset state IDLE.
REQ-012 in_ready SHALL be 1 in IDLE and 0 in MUL (combinational from state).
REQ-013 Accept = in_valid & in_ready at a rising edge.
REQ-014 Operand B = ALUSrc ? imm_data : ReadData2; operand A = ReadData1.
REQ-015 ALUOp 00: A+B; 01: A-B; 10: per Funct; 11: multiply (low 64 bits of A*B, unsigned shift-add).
REQ-016 ALUOp 10 decode: 0000 add, 1000 sub, 0111 and, 0110 or, 0100 xor, 0001 sll, 0101 srl, 1101 sra, 0010 slt (signed), 0011 sltu; other codes -> result 0.
REQ-017 Shifts SHALL use B[5:0] as shift amount; all add/sub wrap modulo 2^64.
REQ-018 Non-multiply accept: all outputs register at that same edge (latency 1); valid_out=1; state stays IDLE.
REQ-019 Outputs on completion: Zero = (ALU_result==0); PCSrc = Branch & Zero; branch_target = PC + (imm_data<<1); WriteData = ReadData2; rd and control bits copied.
REQ-020 Multiply accept: latch A, B, PC, imm, rd, controls; count=0; state -> MUL; valid_out=0 and all control outputs 0 at that edge.
REQ-021 MUL: one shift-add iteration per cycle; at the 64th MUL edge (accept edge + 64) results register, valid_out=1, state -> IDLE.
REQ-022 While in MUL, ID/EX inputs SHALL be ignored; valid_out, PCSrc, Branch_out, MemRead_out, MemWrite_out, Regwrite_out SHALL be 0 (bubble).
REQ-023 IDLE with in_valid=0: at edge, valid_out and all control outputs cleared to 0 (bubble); data outputs may hold.
REQ-024 Back-to-back: instruction accepted on the edge that completes a multiply is not possible (in_ready=0); first accept is the next edge.
REQ-025 Multiply result SHALL equal (A*B) mod 2^64 for all operands, including 0 and all-ones.

Reset
REQ-026 reset=0 SHALL immediately clear state to IDLE, count to 0, and every output register (ALU_result, WriteData, branch_target, rd_out, Zero, PCSrc, valid_out, all control outs) to 0.
REQ-027 reset asserted mid-multiply SHALL abort the operation; no valid_out for it after release.
REQ-028 After reset release, first accept is allowed at the first rising edge with reset=1.

Verification
REQ-029 ADD: ALUOp=10, Funct=0000, A=5, B=7, Regwrite=1, rd=3 -> next edge ALU_result=12, Zero=0, rd_out=3, Regwrite_out=1, valid_out=1.
REQ-030 BEQ: ALUOp=01, A=B=0x10, Branch=1, PC=0x100, imm=8 -> Zero=1, PCSrc=1, branch_target=0x110.
REQ-031 Load address: ALUOp=00, ALUSrc=1, A=0x1000, imm=0xFFFF_FFFF_FFFF_FFF8, MemRead=1 -> ALU_result=0xFF8, MemRead_out=1.
REQ-032 MUL: ALUOp=11, A=0xFFFF_FFFF_FFFF_FFFF, B=3 -> in_ready=0 for 64 cycles, valid_out=0 meanwhile, then ALU_result=0xFFFF_FFFF_FFFF_FFFD, valid_out=1.
REQ-033 Reset at MUL cycle 30 -> all outputs 0 immediately, state IDLE, in_ready=1 after release, no stale valid_out.
REQ-034 SRA: Funct=1101, A=0x8000_0000_0000_0000, B=63 -> ALU_result=0xFFFF_FFFF_FFFF_FFFF; then in_valid=0 -> valid_out=0, controls 0.
